// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared constants and per-counter state for the 8254-style
//               bus interface unit. Read-back fields exist only with READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    localparam logic [1:0] RW_LATCH    = 2'b00;
    localparam logic [1:0] RW_LSB      = 2'b01;
    localparam logic [1:0] RW_MSB      = 2'b10;
    localparam logic [1:0] RW_WORD     = 2'b11;

    localparam logic [1:0] A_CTRL      = 2'b11;
    localparam logic [1:0] SC_READBACK = 2'b11;

    localparam int CW_SC_POS = 6;
    localparam int CW_RW_POS = 4;
`ifdef READBACK_EN
    localparam int CW_RB_SEL_POS = 1;
    localparam int CW_RB_NCNT    = 5;
    localparam int CW_RB_NSTS    = 4;
`endif

    typedef enum logic {
        PTR_LSB = 1'b0,
        PTR_MSB = 1'b1
    } ptr_e;

    typedef struct packed {
        logic [1:0] rw;
        ptr_e       wr_ptr;
        ptr_e       rd_ptr;
        logic       cnt_latched;
        logic       sts_latched;
    } cnt_state_t;

    localparam cnt_state_t CNT_STATE_RESET = '{
        rw: RW_LATCH, wr_ptr: PTR_LSB, rd_ptr: PTR_LSB,
        cnt_latched: 1'b0, sts_latched: 1'b0
    };

endpackage
`default_nettype wire

// File: rtl/bus_sync.sv
`default_nettype none
// ============================================================================
// Module      : bus_sync
// Description : Optional synchroniser on CS/RD/WR plus write-event and
//               read-end edge detection.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_sync #(
    parameter int SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_cs_n,
    input  logic i_rd_n,
    input  logic i_wr_n,
    output logic o_cs_n,
    output logic o_rd_n,
    output logic o_wr_n,
    output logic o_wr_evt,
    output logic o_rd_end
);

    logic [2:0] w_bus;   // {cs_n, rd_n, wr_n}

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [2:0] r_sync_q [SYNC_STAGES];
            logic [2:0] w_sync_d [SYNC_STAGES];

            always_comb begin
                w_sync_d[0] = {i_cs_n, i_rd_n, i_wr_n};
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    w_sync_d[k] = r_sync_q[k-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        r_sync_q[k] <= 3'b111;
                    end
                end else begin
                    r_sync_q <= w_sync_d;
                end
            end

            assign w_bus = r_sync_q[SYNC_STAGES-1];
        end else begin : g_nosync
            assign w_bus = {i_cs_n, i_rd_n, i_wr_n};
        end
    endgenerate

    logic [2:0] r_prev_q, w_prev_d;
    logic       r_rd_bad_q, w_rd_bad_d;

    // A read that overlapped WR (illegal) must not advance the read pointer.
    always_comb begin
        w_prev_d   = w_bus;
        w_rd_bad_d = w_bus[1] ? 1'b0 : (r_rd_bad_q | (~w_bus[2] & ~w_bus[0]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_q   <= 3'b111;
            r_rd_bad_q <= 1'b0;
        end else begin
            r_prev_q   <= w_prev_d;
            r_rd_bad_q <= w_rd_bad_d;
        end
    end

    assign o_cs_n   = w_bus[2];
    assign o_rd_n   = w_bus[1];
    assign o_wr_n   = w_bus[0];
    assign o_wr_evt = r_prev_q[0] & ~w_bus[0] & ~w_bus[2] & w_bus[1];
    assign o_rd_end = ~r_prev_q[1] & w_bus[1] & ~r_prev_q[2] & ~r_rd_bad_q;

endmodule
`default_nettype wire

// File: rtl/bus_interface_unit.sv
`default_nettype none
// ============================================================================
// Module      : bus_interface_unit
// Description : 8254-style read/write logic and data-bus buffer for up to
//               three counters. Macro READBACK_EN enables the read-back command.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_interface_unit
    import timer_pkg::*;
#(
    parameter int NUM_COUNTERS = 3,
    parameter int SYNC_STAGES  = 0
) (
    input  logic                        global_CLK,
    input  logic                        RESET,
    input  logic                        CS,
    input  logic                        RD,
    input  logic                        WR,
    input  logic [1:0]                  A,
    input  logic [7:0]                  D_in,
    output logic [7:0]                  D_out,
    output logic                        D_oe,
    input  logic [8*NUM_COUNTERS-1:0]   cnt_data,
    output logic [7:0]                  control_word,
    output logic [NUM_COUNTERS-1:0]     ctrl_wr,
    output logic [15:0]                 in_count,
    output logic [NUM_COUNTERS-1:0]     cnt_load,
    output logic [NUM_COUNTERS-1:0]     latch_cnt,
    output logic [NUM_COUNTERS-1:0]     latch_sts,
    output logic [2*NUM_COUNTERS-1:0]   out_count_enable,
    output logic [NUM_COUNTERS-1:0]     out_status_enable
);

    logic w_cs_n, w_rd_n, w_wr_n, w_wr_evt, w_rd_end;

    bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk      (global_CLK),
        .rst      (RESET),
        .i_cs_n   (CS),
        .i_rd_n   (RD),
        .i_wr_n   (WR),
        .o_cs_n   (w_cs_n),
        .o_rd_n   (w_rd_n),
        .o_wr_n   (w_wr_n),
        .o_wr_evt (w_wr_evt),
        .o_rd_end (w_rd_end)
    );

    cnt_state_t              r_cnt_q  [NUM_COUNTERS];
    cnt_state_t              w_cnt_d  [NUM_COUNTERS];
    logic [7:0]              r_hold_q [NUM_COUNTERS];
    logic [7:0]              w_hold_d [NUM_COUNTERS];
    logic [7:0]              r_control_word_q, w_control_word_d;
    logic [15:0]             r_in_count_q, w_in_count_d;
    logic [NUM_COUNTERS-1:0] r_ctrl_wr_q, w_ctrl_wr_d;
    logic [NUM_COUNTERS-1:0] r_cnt_load_q, w_cnt_load_d;
    logic [NUM_COUNTERS-1:0] r_latch_cnt_q, w_latch_cnt_d;
    logic [NUM_COUNTERS-1:0] r_latch_sts_q, w_latch_sts_d;
    logic [1:0]              r_rd_sel_q, w_rd_sel_d;

    logic       w_rd_active;
    logic [1:0] w_sc;
    logic [1:0] w_rw;

    assign w_rd_active = ~RESET & ~w_cs_n & ~w_rd_n & w_wr_n;
    assign w_sc        = D_in[CW_SC_POS +: 2];
    assign w_rw        = D_in[CW_RW_POS +: 2];

    always_comb begin
        w_cnt_d          = r_cnt_q;
        w_hold_d         = r_hold_q;
        w_control_word_d = r_control_word_q;
        w_in_count_d     = r_in_count_q;
        w_ctrl_wr_d      = '0;
        w_cnt_load_d     = '0;
        w_latch_cnt_d    = '0;
        w_latch_sts_d    = '0;
        w_rd_sel_d       = w_rd_active ? A : r_rd_sel_q;

        // Read-end is applied first so a write in the same cycle sees it.
        if (w_rd_end) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                if (r_rd_sel_q == 2'(i)) begin
                    if (r_cnt_q[i].sts_latched) begin
                        w_cnt_d[i].sts_latched = 1'b0;
                    end else if (r_cnt_q[i].rw == RW_WORD && r_cnt_q[i].rd_ptr == PTR_LSB) begin
                        w_cnt_d[i].rd_ptr = PTR_MSB;
                    end else begin
                        w_cnt_d[i].rd_ptr      = PTR_LSB;
                        w_cnt_d[i].cnt_latched = 1'b0;
                    end
                end
            end
        end

        if (w_wr_evt) begin
            if (A == A_CTRL) begin
                if (w_sc == SC_READBACK) begin
`ifdef READBACK_EN
                    for (int i = 0; i < NUM_COUNTERS; i++) begin
                        if (D_in[CW_RB_SEL_POS + i]) begin
                            if (!D_in[CW_RB_NCNT] && !w_cnt_d[i].cnt_latched) begin
                                w_latch_cnt_d[i]       = 1'b1;
                                w_cnt_d[i].cnt_latched = 1'b1;
                            end
                            if (!D_in[CW_RB_NSTS] && !w_cnt_d[i].sts_latched) begin
                                w_latch_sts_d[i]       = 1'b1;
                                w_cnt_d[i].sts_latched = 1'b1;
                            end
                        end
                    end
`endif
                end else begin
                    for (int i = 0; i < NUM_COUNTERS; i++) begin
                        if (w_sc == 2'(i)) begin
                            if (w_rw != RW_LATCH) begin
                                w_cnt_d[i]       = CNT_STATE_RESET;
                                w_cnt_d[i].rw    = w_rw;
                                w_hold_d[i]      = 8'h00;
                                w_control_word_d = D_in;
                                w_ctrl_wr_d[i]   = 1'b1;
                            end else if (!w_cnt_d[i].cnt_latched) begin
                                w_latch_cnt_d[i]       = 1'b1;
                                w_cnt_d[i].cnt_latched = 1'b1;
                            end
                        end
                    end
                end
            end else begin
                for (int i = 0; i < NUM_COUNTERS; i++) begin
                    if (A == 2'(i)) begin
                        case (w_cnt_d[i].rw)
                            RW_LSB: begin
                                w_in_count_d    = {8'h00, D_in};
                                w_cnt_load_d[i] = 1'b1;
                            end
                            RW_MSB: begin
                                w_in_count_d    = {D_in, 8'h00};
                                w_cnt_load_d[i] = 1'b1;
                            end
                            RW_WORD: begin
                                if (w_cnt_d[i].wr_ptr == PTR_LSB) begin
                                    w_hold_d[i]       = D_in;
                                    w_cnt_d[i].wr_ptr = PTR_MSB;
                                end else begin
                                    w_in_count_d      = {D_in, r_hold_q[i]};
                                    w_cnt_load_d[i]   = 1'b1;
                                    w_cnt_d[i].wr_ptr = PTR_LSB;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge global_CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                r_cnt_q[i]  <= CNT_STATE_RESET;
                r_hold_q[i] <= 8'h00;
            end
            r_control_word_q <= 8'h00;
            r_in_count_q     <= 16'h0000;
            r_ctrl_wr_q      <= '0;
            r_cnt_load_q     <= '0;
            r_latch_cnt_q    <= '0;
            r_latch_sts_q    <= '0;
            r_rd_sel_q       <= 2'b00;
        end else begin
            r_cnt_q          <= w_cnt_d;
            r_hold_q         <= w_hold_d;
            r_control_word_q <= w_control_word_d;
            r_in_count_q     <= w_in_count_d;
            r_ctrl_wr_q      <= w_ctrl_wr_d;
            r_cnt_load_q     <= w_cnt_load_d;
            r_latch_cnt_q    <= w_latch_cnt_d;
            r_latch_sts_q    <= w_latch_sts_d;
            r_rd_sel_q       <= w_rd_sel_d;
        end
    end

    // Read steering: latched status takes priority over the count bytes.
    always_comb begin
        D_oe              = 1'b0;
        D_out             = 8'h00;
        out_count_enable  = '0;
        out_status_enable = '0;
        if (w_rd_active) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                if (A == 2'(i)) begin
                    D_oe  = 1'b1;
                    D_out = cnt_data[8*i +: 8];
                    if (r_cnt_q[i].sts_latched) begin
                        out_status_enable[i] = 1'b1;
                    end else begin
                        case (r_cnt_q[i].rw)
                            RW_LSB:  out_count_enable[2*i +: 2] = 2'b01;
                            RW_MSB:  out_count_enable[2*i +: 2] = 2'b10;
                            RW_WORD: out_count_enable[2*i +: 2] =
                                         (r_cnt_q[i].rd_ptr == PTR_MSB) ? 2'b10 : 2'b01;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign control_word = r_control_word_q;
    assign ctrl_wr      = r_ctrl_wr_q;
    assign in_count     = r_in_count_q;
    assign cnt_load     = r_cnt_load_q;
    assign latch_cnt    = r_latch_cnt_q;
    assign latch_sts    = r_latch_sts_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_interface_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_interface_unit
// Description : Directed self-checking bench for bus_interface_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_interface_unit;

    logic        clk;
    logic        rst;
    logic        cs_n, rd_n, wr_n;
    logic [1:0]  a;
    logic [7:0]  d_in;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [23:0] cnt_data;
    logic [7:0]  control_word;
    logic [2:0]  ctrl_wr, cnt_load, latch_cnt, latch_sts, out_status_enable;
    logic [15:0] in_count;
    logic [5:0]  out_count_enable;

    int errors = 0;
    int checks = 0;

    logic [2:0]  obs_ctrl_wr, obs_cnt_load, obs_latch_cnt, obs_latch_sts;
    logic [15:0] obs_in_count;
    logic [7:0]  obs_cw;
    logic        obs_doe;
    logic [7:0]  obs_dout;
    logic [5:0]  obs_oce;
    logic [2:0]  obs_ose;

    bus_interface_unit #(
        .NUM_COUNTERS (3),
        .SYNC_STAGES  (0)
    ) dut (
        .global_CLK        (clk),
        .RESET             (rst),
        .CS                (cs_n),
        .RD                (rd_n),
        .WR                (wr_n),
        .A                 (a),
        .D_in              (d_in),
        .D_out             (d_out),
        .D_oe              (d_oe),
        .cnt_data          (cnt_data),
        .control_word      (control_word),
        .ctrl_wr           (ctrl_wr),
        .in_count          (in_count),
        .cnt_load          (cnt_load),
        .latch_cnt         (latch_cnt),
        .latch_sts         (latch_sts),
        .out_count_enable  (out_count_enable),
        .out_status_enable (out_status_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle write strobe; registered strobes are captured one cycle later.
    task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
        @(posedge clk); #1;
        a = addr; d_in = data; cs_n = 1'b0; wr_n = 1'b0;
        @(posedge clk); #1;
        obs_ctrl_wr   = ctrl_wr;
        obs_cnt_load  = cnt_load;
        obs_latch_cnt = latch_cnt;
        obs_latch_sts = latch_sts;
        obs_in_count  = in_count;
        obs_cw        = control_word;
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] addr);
        @(posedge clk); #1;
        a = addr; cs_n = 1'b0; rd_n = 1'b0;
        @(negedge clk);
        obs_doe  = d_oe;
        obs_dout = d_out;
        obs_oce  = out_count_enable;
        obs_ose  = out_status_enable;
        @(posedge clk); #1;
        cs_n = 1'b1; rd_n = 1'b1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset();
        @(negedge clk);
        checks++; if (control_word !== 8'h00) begin errors++; $display("FAIL reset control_word: got %h expected 00", control_word); end
        checks++; if (in_count !== 16'h0000) begin errors++; $display("FAIL reset in_count: got %h expected 0000", in_count); end
        checks++; if ({ctrl_wr, cnt_load, latch_cnt, latch_sts} !== 12'h000) begin errors++; $display("FAIL reset strobes: got %h expected 000", {ctrl_wr, cnt_load, latch_cnt, latch_sts}); end
        checks++; if ({d_oe, d_out} !== 9'h000) begin errors++; $display("FAIL reset read bus: got %h expected 000", {d_oe, d_out}); end
        checks++; if ({out_count_enable, out_status_enable} !== 9'h000) begin errors++; $display("FAIL reset enables: got %h expected 000", {out_count_enable, out_status_enable}); end
    endtask

    task automatic test_word_write();
        bus_write(2'b11, 8'h34);
        checks++; if (obs_ctrl_wr !== 3'b001) begin errors++; $display("FAIL word ctrl_wr: got %b expected 001", obs_ctrl_wr); end
        checks++; if (obs_cw !== 8'h34) begin errors++; $display("FAIL word control_word: got %h expected 34", obs_cw); end
        bus_write(2'b00, 8'hE8);
        checks++; if (obs_cnt_load !== 3'b000) begin errors++; $display("FAIL word lsb no load: got %b expected 000", obs_cnt_load); end
        bus_write(2'b00, 8'h03);
        checks++; if (obs_cnt_load !== 3'b001) begin errors++; $display("FAIL word msb load: got %b expected 001", obs_cnt_load); end
        checks++; if (obs_in_count !== 16'h03E8) begin errors++; $display("FAIL word in_count: got %h expected 03e8", obs_in_count); end
        @(posedge clk); #1;
        checks++; if (cnt_load !== 3'b000) begin errors++; $display("FAIL word load width: got %b expected 000", cnt_load); end
    endtask

    task automatic test_byte_modes();
        bus_write(2'b11, 8'h60);
        checks++; if (obs_ctrl_wr !== 3'b010) begin errors++; $display("FAIL msb ctrl_wr: got %b expected 010", obs_ctrl_wr); end
        bus_write(2'b01, 8'h12);
        checks++; if (obs_cnt_load !== 3'b010) begin errors++; $display("FAIL msb cnt_load: got %b expected 010", obs_cnt_load); end
        checks++; if (obs_in_count !== 16'h1200) begin errors++; $display("FAIL msb in_count: got %h expected 1200", obs_in_count); end
        bus_write(2'b10, 8'h77);
        checks++; if ({obs_ctrl_wr, obs_cnt_load} !== 6'b000000) begin errors++; $display("FAIL unprog strobes: got %b expected 000000", {obs_ctrl_wr, obs_cnt_load}); end
        checks++; if (obs_in_count !== 16'h1200) begin errors++; $display("FAIL unprog in_count: got %h expected 1200", obs_in_count); end
        bus_write(2'b11, 8'h90);
        bus_write(2'b10, 8'h5A);
        checks++; if (obs_cnt_load !== 3'b100) begin errors++; $display("FAIL lsb cnt_load: got %b expected 100", obs_cnt_load); end
        checks++; if (obs_in_count !== 16'h005A) begin errors++; $display("FAIL lsb in_count: got %h expected 005a", obs_in_count); end
    endtask

    task automatic test_counter_latch();
        bus_write(2'b11, 8'h34);
        bus_write(2'b11, 8'h00);
        checks++; if (obs_latch_cnt !== 3'b001) begin errors++; $display("FAIL latch first: got %b expected 001", obs_latch_cnt); end
        checks++; if (obs_cw !== 8'h34) begin errors++; $display("FAIL latch control_word: got %h expected 34", obs_cw); end
        bus_write(2'b11, 8'h00);
        checks++; if (obs_latch_cnt !== 3'b000) begin errors++; $display("FAIL latch second: got %b expected 000", obs_latch_cnt); end
        bus_read(2'b00);
        checks++; if ({obs_doe, obs_dout} !== 9'h1A0) begin errors++; $display("FAIL latch read data: got %h expected 1a0", {obs_doe, obs_dout}); end
        checks++; if ({obs_oce, obs_ose} !== 9'b000001_000) begin errors++; $display("FAIL latch read lsb: got %b expected 000001000", {obs_oce, obs_ose}); end
        bus_read(2'b00);
        checks++; if (obs_oce !== 6'b000010) begin errors++; $display("FAIL latch read msb: got %b expected 000010", obs_oce); end
        bus_write(2'b11, 8'h00);
        checks++; if (obs_latch_cnt !== 3'b001) begin errors++; $display("FAIL latch third: got %b expected 001", obs_latch_cnt); end
        bus_read(2'b01);
        checks++; if ({obs_dout, obs_oce} !== {8'hB1, 6'b001000}) begin errors++; $display("FAIL ctr1 read: got %h expected b1_08", {obs_dout, obs_oce}); end
    endtask

    task automatic test_lsb_discard();
        bus_write(2'b00, 8'hAA);
        checks++; if (obs_cnt_load !== 3'b000) begin errors++; $display("FAIL discard lsb: got %b expected 000", obs_cnt_load); end
        bus_write(2'b11, 8'h30);
        checks++; if ({obs_ctrl_wr, obs_cw} !== {3'b001, 8'h30}) begin errors++; $display("FAIL discard cw: got %h expected 130", {obs_ctrl_wr, obs_cw}); end
        bus_write(2'b00, 8'h55);
        checks++; if (obs_cnt_load !== 3'b000) begin errors++; $display("FAIL discard relsb: got %b expected 000", obs_cnt_load); end
        bus_write(2'b00, 8'h00);
        checks++; if (obs_cnt_load !== 3'b001) begin errors++; $display("FAIL discard load: got %b expected 001", obs_cnt_load); end
        checks++; if (obs_in_count !== 16'h0055) begin errors++; $display("FAIL discard in_count: got %h expected 0055", obs_in_count); end
    endtask

    task automatic test_illegal();
        @(posedge clk); #1;
        a = 2'b00; d_in = 8'h99; cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        checks++; if (d_oe !== 1'b0) begin errors++; $display("FAIL illegal d_oe: got %b expected 0", d_oe); end
        @(posedge clk); #1;
        checks++; if ({ctrl_wr, cnt_load} !== 6'b000000) begin errors++; $display("FAIL illegal strobes: got %b expected 000000", {ctrl_wr, cnt_load}); end
        cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        bus_write(2'b00, 8'h11);
        checks++; if (obs_cnt_load !== 3'b000) begin errors++; $display("FAIL illegal wr_ptr: got %b expected 000", obs_cnt_load); end
        bus_write(2'b00, 8'h22);
        checks++; if ({obs_cnt_load, obs_in_count} !== {3'b001, 16'h2211}) begin errors++; $display("FAIL illegal reload: got %h expected 12211", {obs_cnt_load, obs_in_count}); end
        bus_read(2'b00);
        checks++; if (obs_oce !== 6'b000001) begin errors++; $display("FAIL illegal rd_ptr: got %b expected 000001", obs_oce); end
        bus_read(2'b00);
        checks++; if (obs_oce !== 6'b000010) begin errors++; $display("FAIL illegal rd msb: got %b expected 000010", obs_oce); end
        bus_read(2'b11);
        checks++; if ({obs_doe, obs_dout} !== 9'h000) begin errors++; $display("FAIL ctrl read: got %h expected 000", {obs_doe, obs_dout}); end
    endtask

    task automatic test_reset_mid();
        bus_write(2'b00, 8'hAA);
        checks++; if (obs_cnt_load !== 3'b000) begin errors++; $display("FAIL rstmid lsb: got %b expected 000", obs_cnt_load); end
        pulse_reset();
        bus_write(2'b00, 8'h55);
        checks++; if ({obs_cnt_load, obs_in_count} !== 19'h0) begin errors++; $display("FAIL rstmid unprog: got %h expected 0", {obs_cnt_load, obs_in_count}); end
        bus_read(2'b00);
        checks++; if ({obs_doe, obs_oce} !== 7'b1_000000) begin errors++; $display("FAIL rstmid read: got %b expected 1000000", {obs_doe, obs_oce}); end
        bus_write(2'b11, 8'h30);
        bus_write(2'b00, 8'h11);
        checks++; if (obs_cnt_load !== 3'b000) begin errors++; $display("FAIL rstmid ptr: got %b expected 000", obs_cnt_load); end
        bus_write(2'b00, 8'h22);
        checks++; if (obs_in_count !== 16'h2211) begin errors++; $display("FAIL rstmid in_count: got %h expected 2211", obs_in_count); end
    endtask

    task automatic test_readback();
        bus_write(2'b11, 8'h30);
        bus_write(2'b11, 8'hB0);
        bus_write(2'b11, 8'hCA);
`ifdef READBACK_EN
        checks++; if (obs_latch_cnt !== 3'b101) begin errors++; $display("FAIL rb latch_cnt: got %b expected 101", obs_latch_cnt); end
        checks++; if (obs_latch_sts !== 3'b101) begin errors++; $display("FAIL rb latch_sts: got %b expected 101", obs_latch_sts); end
        checks++; if (obs_ctrl_wr !== 3'b000) begin errors++; $display("FAIL rb ctrl_wr: got %b expected 000", obs_ctrl_wr); end
        bus_read(2'b00);
        checks++; if ({obs_ose, obs_oce} !== 9'b001_000000) begin errors++; $display("FAIL rb status read: got %b expected 001000000", {obs_ose, obs_oce}); end
        bus_read(2'b00);
        checks++; if ({obs_ose, obs_oce} !== 9'b000_000001) begin errors++; $display("FAIL rb count read: got %b expected 000000001", {obs_ose, obs_oce}); end
`else
        checks++; if ({obs_ctrl_wr, obs_latch_cnt, obs_latch_sts} !== 9'h000) begin errors++; $display("FAIL sc11 strobes: got %b expected 000000000", {obs_ctrl_wr, obs_latch_cnt, obs_latch_sts}); end
        checks++; if (obs_cw !== 8'hB0) begin errors++; $display("FAIL sc11 control_word: got %h expected b0", obs_cw); end
        bus_read(2'b00);
        checks++; if ({obs_ose, obs_oce} !== 9'b000_000001) begin errors++; $display("FAIL sc11 read: got %b expected 000000001", {obs_ose, obs_oce}); end
`endif
    endtask

    initial begin
        rst = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        a = 2'b00; d_in = 8'h00;
        cnt_data = 24'hC2B1A0;
        test_reset();
        test_word_write();
        test_byte_modes();
        test_counter_latch();
        test_lsb_discard();
        test_illegal();
        test_reset_mid();
        test_readback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
